// File: rtl/range_tuner_seq.sv
// Maps a raw number onto [min, max] as min + (number mod span) using a
// bit-serial restoring divider behind valid/ready handshakes.
module range_tuner_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] number,
    input  logic [WIDTH-1:0] min,
    input  logic [WIDTH-1:0] max,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] tuned,
    output logic             err
);

    localparam int unsigned SW = WIDTH + 1;
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [SW-1:0] FULL_SPAN = SW'(1) << WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [SW-1:0]   r_span;
    logic [SW-1:0]   r_rem;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_min;
    logic [CW-1:0]   r_cnt;

    logic [SW-1:0]   w_span;
    logic [SW-1:0]   w_rem_sh;
    logic [SW-1:0]   w_rem_nx;
    logic            w_accept;

    // Span is computed one bit wider so the full range 2^WIDTH is representable.
    assign w_span   = {1'b0, max} - {1'b0, min} + SW'(1);
    assign w_accept = in_valid && in_ready;

    // One restoring-division step: bring in the next dividend bit, subtract if it fits.
    assign w_rem_sh = (r_rem << 1) | SW'(r_shift[WIDTH-1]);
    assign w_rem_nx = (w_rem_sh >= r_span) ? (w_rem_sh - r_span) : w_rem_sh;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_span    <= '0;
            r_rem     <= '0;
            r_shift   <= '0;
            r_min     <= '0;
            r_cnt     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            tuned     <= '0;
            err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        in_ready <= 1'b0;
                        r_min    <= min;
                        r_span   <= w_span;
                        if (min > max) begin
                            tuned     <= min;
                            err       <= 1'b1;
                            out_valid <= 1'b1;
                            r_state   <= S_DONE;
                        end else if (w_span == FULL_SPAN) begin
                            tuned     <= number;
                            err       <= 1'b0;
                            out_valid <= 1'b1;
                            r_state   <= S_DONE;
                        end else if (w_span == SW'(1)) begin
                            tuned     <= min;
                            err       <= 1'b0;
                            out_valid <= 1'b1;
                            r_state   <= S_DONE;
                        end else begin
                            r_rem   <= '0;
                            r_shift <= number;
                            r_cnt   <= CW'(WIDTH);
                            r_state <= S_DIV;
                        end
                    end
                end
                S_DIV: begin
                    r_rem   <= w_rem_nx;
                    r_shift <= r_shift << 1;
                    r_cnt   <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        // Remainder is below span, so the add cannot wrap.
                        tuned     <= WIDTH'(w_rem_nx + {1'b0, r_min});
                        err       <= 1'b0;
                        out_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_range_tuner_seq.sv
// Directed self-checking bench for range_tuner_seq at WIDTH=8.
module tb_range_tuner_seq;

    localparam int unsigned W = 8;

    logic         clk;
    logic         resetn;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] number;
    logic [W-1:0] min;
    logic [W-1:0] max;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] tuned;
    logic         err;

    int checks;
    int errors;

    range_tuner_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .number    (number),
        .min       (min),
        .max       (max),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .tuned     (tuned),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Vector table: number, min, max, expected tuned, expected err, expected edges
    logic [W-1:0] tv_n   [6];
    logic [W-1:0] tv_mn  [6];
    logic [W-1:0] tv_mx  [6];
    logic [W-1:0] tv_exp [6];
    logic         tv_err [6];
    int           tv_lat [6];

    // Presents one request, then waits (bounded) for out_valid; edges counts from the accept edge.
    task automatic issue(input logic [W-1:0] n, input logic [W-1:0] mn,
                         input logic [W-1:0] mx, output int edges);
        in_valid = 1'b1;
        number   = n;
        min      = mn;
        max      = mx;
        @(posedge clk); #1;
        in_valid = 1'b0;
        edges    = 1;
        while (!out_valid && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic handshake;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        checks++;
        if (tuned !== 8'd0) begin
            errors++;
            $display("FAIL reset_tuned got %0d want 0", tuned);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err got %b want 0", err);
        end
    endtask

    task automatic test_divide;
        int e;
        issue(8'd200, 8'd3, 8'd9, e);
        checks++;
        if (e !== 9) begin
            errors++;
            $display("FAIL div_latency got %0d want 9", e);
        end
        checks++;
        if (tuned !== 8'd7) begin
            errors++;
            $display("FAIL div_tuned got %0d want 7", tuned);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL div_err got %b want 0", err);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (tuned !== 8'd7 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL div_hold cycle %0d got tuned=%0d in_ready=%b out_valid=%b want 7/0/1",
                         i, tuned, in_ready, out_valid);
            end
        end
        handshake();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL div_release got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_fast_and_boundary;
        int e;
        for (int k = 0; k < 6; k++) begin
            issue(tv_n[k], tv_mn[k], tv_mx[k], e);
            checks++;
            if (tuned !== tv_exp[k] || err !== tv_err[k]) begin
                errors++;
                $display("FAIL vec%0d result got tuned=%0d err=%b want tuned=%0d err=%b",
                         k, tuned, err, tv_exp[k], tv_err[k]);
            end
            checks++;
            if (e !== tv_lat[k]) begin
                errors++;
                $display("FAIL vec%0d latency got %0d want %0d", k, e, tv_lat[k]);
            end
            handshake();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL vec%0d release got out_valid=%b in_ready=%b want 0/1",
                         k, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_input_stability;
        int e;
        in_valid = 1'b1;
        number   = 8'd200;
        min      = 8'd3;
        max      = 8'd9;
        @(posedge clk); #1;
        e = 1;
        while (!out_valid && e < 40) begin
            number = 8'($urandom);
            min    = 8'($urandom);
            max    = 8'($urandom);
            @(posedge clk); #1;
            e++;
        end
        in_valid = 1'b0;
        checks++;
        if (e !== 9 || tuned !== 8'd7 || err !== 1'b0) begin
            errors++;
            $display("FAIL stability got edges=%0d tuned=%0d err=%b want 9/7/0", e, tuned, err);
        end
        handshake();
    endtask

    task automatic test_reset_mid_op;
        int e;
        int pulses;
        in_valid = 1'b1;
        number   = 8'd100;
        min      = 8'd0;
        max      = 8'd6;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        resetn = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || tuned !== 8'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state got out_valid=%b in_ready=%b tuned=%0d err=%b want 0/1/0/0",
                     out_valid, in_ready, tuned, err);
        end
        pulses = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (out_valid) pulses++;
        end
        resetn = 1'b1;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL midreset_pulse got %0d out_valid cycles want 0", pulses);
        end
        issue(8'd10, 8'd0, 8'd3, e);
        checks++;
        if (tuned !== 8'd2 || err !== 1'b0 || e !== 9) begin
            errors++;
            $display("FAIL midreset_fresh got tuned=%0d err=%b edges=%0d want 2/0/9", tuned, err, e);
        end
        handshake();
    endtask

    initial begin
        clk       = 1'b0;
        resetn    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        number    = '0;
        min       = '0;
        max       = '0;
        checks    = 0;
        errors    = 0;

        tv_n[0] = 8'd77;  tv_mn[0] = 8'd0;   tv_mx[0] = 8'd255; tv_exp[0] = 8'd77;  tv_err[0] = 1'b0; tv_lat[0] = 1;
        tv_n[1] = 8'd123; tv_mn[1] = 8'd42;  tv_mx[1] = 8'd42;  tv_exp[1] = 8'd42;  tv_err[1] = 1'b0; tv_lat[1] = 1;
        tv_n[2] = 8'd5;   tv_mn[2] = 8'd9;   tv_mx[2] = 8'd3;   tv_exp[2] = 8'd9;   tv_err[2] = 1'b1; tv_lat[2] = 1;
        tv_n[3] = 8'd255; tv_mn[3] = 8'd0;   tv_mx[3] = 8'd254; tv_exp[3] = 8'd0;   tv_err[3] = 1'b0; tv_lat[3] = 9;
        tv_n[4] = 8'd0;   tv_mn[4] = 8'd100; tv_mx[4] = 8'd200; tv_exp[4] = 8'd100; tv_err[4] = 1'b0; tv_lat[4] = 9;
        tv_n[5] = 8'd254; tv_mn[5] = 8'd1;   tv_mx[5] = 8'd255; tv_exp[5] = 8'd255; tv_err[5] = 1'b0; tv_lat[5] = 9;

        #22;
        test_reset();
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        test_divide();
        test_fast_and_boundary();
        test_input_stability();
        test_reset_mid_op();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/range_tuner_seq.md
Name: range_tuner_seq

Overview:
- Sequential, parametrised successor to the combinational number tuner.
- Maps a raw (typically LFSR/random) number onto the inclusive interval [min, max]: `tuned = min + (number mod (max - min + 1))`.
- Uses a WIDTH-cycle restoring divider instead of a wide combinational divide and power operator.
- Valid/ready handshakes on both sides, so game logic (mole position, delay selection) can stall it.

Parameters:
- WIDTH, 16, bit width of number, min, max and result (must be ≥ 2).

Ports:
- clk  input  1  system clock, all state updates on its rising edge.
- resetn  input  1  asynchronous, active-low reset.
- in_valid  input  1  request present on number/min/max.
- in_ready  output  1  block can accept a request.
- number  input  WIDTH  raw value to map.
- min  input  WIDTH  inclusive lower bound.
- max  input  WIDTH  inclusive upper bound.
- out_valid  output  1  result/err valid.
- out_ready  input  1  consumer accepts result.
- tuned  output  WIDTH  mapped value.
- err  output  1  request had min > max.

Behaviour:
- Clock/reset: one clock (clk); resetn is asynchronous, active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, tuned=0, err=0, all internal registers 0.
- Accept: a request is accepted on a rising edge with in_valid && in_ready; number/min/max are latched at that edge. Later input changes are ignored.
- States:
  - IDLE: in_ready=1. On accept, compute `span = max - min + 1` in WIDTH+1 bits, then go to:
    - DONE with tuned=min, err=1 if min > max.
    - DONE with tuned=number, err=0 if span == 2^WIDTH (full range).
    - DONE with tuned=min, err=0 if span == 1.
    - DIV otherwise: remainder register=0, quotient-shift register=number, count=WIDTH.
  - DIV: in_ready=0. Per cycle, one restoring step:
    - `rem = (rem << 1) | msb(shift)`; shift <<= 1.
    - If rem ≥ span, rem -= span.
    - count decrements; when the last step completes go to DONE with tuned = rem + min (WIDTH-bit add, no overflow possible since rem < span), err=0.
    - rem is WIDTH+1 bits wide to avoid overflow on the shift.
  - DONE: out_valid=1, in_ready=0. tuned/err held stable until the out_ready edge, then return to IDLE (in_ready=1 next cycle).
- Latency, accept edge → out_valid high:
  - Fast paths: 1 edge.
  - Divide path: WIDTH+1 edges.
- Throughput: one request in flight. No new accept before the result handshake completes.
- Simultaneous events: out_ready while out_valid=0 is ignored. A result handshake and a new accept cannot coincide because in_ready=0 in DONE.
- Reset mid-operation: abandons the request immediately, with no output pulse, and returns to reset values.
- Outputs are registered. out_valid never glitches high outside DONE.

Test Plan:
- WIDTH=8, after reset: in_ready=1, out_valid=0, tuned=0, err=0.
- Divide path, number=200, min=3, max=9 (span 7): out_valid after exactly 9 edges, tuned=7, err=0. Then hold out_ready=0 for 5 cycles → tuned stays 7, in_ready stays 0. Then out_ready=1 → out_valid drops and in_ready=1 on the next cycle.
- Fast paths:
  - number=77, min=0, max=255 → tuned=77 after 1 edge.
  - min=max=42 → tuned=42.
  - min=9, max=3 → tuned=9, err=1.
- Boundary values:
  - number=255, min=0, max=254 → tuned=0.
  - number=0, min=100, max=200 → tuned=100.
  - number=254, min=1, max=255 → tuned=255.
- Input stability: change number/min/max every cycle while in DIV → result matches the values latched at accept.
- Reset mid-operation: assert resetn=0 at DIV step 4 → out_valid never pulses. After release, a fresh request (number=10, min=0, max=3) returns tuned=2.
